ghost_motion_ctrl: RTL
======================

GHOST_MOTION_CTRL -- requirements
Module: ghost_motion_ctrl

Interface
REQ-001 SHALL have parameter H_MAX, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_MAX, default 480, visible height in lines.
REQ-003 SHALL have parameter SPR_W, default 16, sprite width and height in pixels.
REQ-004 SHALL have parameter ANIM_DIV, default 8, frames per animation step (range 1-255).
REQ-005 SHALL have ports: clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-006 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: x, y  in  11 each  frame counter pixel position.
REQ-008 SHALL have ports: cpu_cs, cpu_write  in  1 each; cpu_addr  in  14; cpu_wr_data  in  32  upstream video-slot bus.
REQ-009 SHALL have ports: auto_en  in  1  enables motion sequencing.
REQ-010 SHALL have ports: step  in  4  pixels moved per frame per axis (0 = no motion).
REQ-011 SHALL have ports: ctrl_hi  in  3  upper ctrl bits written to sprite ctrl[4:2].
REQ-012 SHALL have ports: m_cs, m_write  out  1 each; m_addr  out  14; m_wr_data  out  32  to the ghost sprite core slot.
REQ-013 SHALL have ports: busy  out  1  high while the FSM is not IDLE; frame_tick  out  1  frame-start pulse.

Function
REQ-014 SHALL assert frame_tick for exactly one cycle, registered, one cycle after x==0 && y==V_MAX is sampled, and never again until the frame counter leaves that pixel.
REQ-015 SHALL implement FSM states IDLE, CALC, WR_X, WR_Y, WR_CTRL.
REQ-016 SHALL move IDLE->CALC on frame_tick && auto_en; CALC->WR_X unconditionally; WR_X->WR_Y, WR_Y->WR_CTRL, WR_CTRL->IDLE each only on a granted bus cycle.
REQ-017 SHALL ignore frame_tick while not in IDLE, with no queuing.
REQ-018 SHALL finish an in-progress sequence if auto_en deasserts mid-sequence.
REQ-019 SHALL hold the 11-bit position x_pos, y_pos and direction bits dx_neg, dy_neg.
REQ-020 SHALL compute in CALC, per axis, the next position = pos +/- step in 12-bit signed arithmetic.
REQ-021 SHALL clamp a next position >(H_MAX-SPR_W) [resp. V_MAX-SPR_W] to that limit and set the direction bit to negative.
REQ-022 SHALL clamp a next position <0 to 0 and clear the direction bit.
REQ-023 SHALL keep a next position exactly at a limit without reversing direction.
REQ-024 SHALL keep frame counter fcnt (8 bits) and 2-bit anim.
REQ-025 SHALL, in CALC, increment fcnt; on fcnt==ANIM_DIV-1, clear fcnt and increment anim mod 4.
REQ-026 SHALL drive these bus writes:
  - WR_X: m_addr=14'h2001, m_wr_data={21'b0,x_pos}
  - WR_Y: m_addr=14'h2002, m_wr_data={21'b0,y_pos}
  - WR_CTRL: m_addr=14'h2003, m_wr_data={27'b0,ctrl_hi,anim}
  - m_cs=m_write=1 in each.
REQ-027 SHALL give the CPU priority: while cpu_cs=1, m_*=cpu_* combinationally and the FSM holds its write state (not granted).
REQ-028 SHALL drive m_cs=m_write=0, m_addr=0, m_wr_data=0 when neither the CPU nor the FSM drives the bus.
REQ-029 SHALL, on a CPU write (cpu_cs&&cpu_write&&cpu_addr[13]) to addr[1:0]==01, load x_pos from cpu_wr_data[10:0] at that clock edge; 10 SHALL load y_pos the same way.
REQ-030 SHALL let a CPU snoop load in the same cycle as CALC take priority over the computed value for that axis.
REQ-031 SHALL leave the FSM unaffected by CPU ctrl writes (addr[1:0]==11); the next WR_CTRL overwrites them.
REQ-032 SHALL produce frame-start-to-last-write latency of 5 cycles with no CPU contention (tick, CALC, WR_X, WR_Y, WR_CTRL), plus one cycle per stalled cycle.

Reset
REQ-033 SHALL, on reset, set: state=IDLE, x_pos=y_pos=0, dx_neg=dy_neg=0, fcnt=0, anim=0, frame_tick=0, busy=0, and m_* outputs idle per REQ-028 unless cpu_cs=1.
REQ-034 SHALL, on reset asserted mid-sequence, abort the sequence with no further FSM writes.

Verification
REQ-035 SHALL cover: auto_en=1, step=4, frame starts from reset -> writes 2001:4, 2002:4, 2003:{ctrl_hi,00} on consecutive cycles after the tick; busy high 4 cycles.
REQ-036 SHALL cover: CPU writes 2001 with 622 (H_MAX-SPR_W=624), step=4 -> next frame x=624 with dx_neg=1; following frame x=620.
REQ-037 SHALL cover: y_pos=2, dy_neg=1, step=5 -> y=0, dy_neg=0; next frame y=5.
REQ-038 SHALL cover: cpu_cs held 3 cycles during WR_Y -> m_* mirror CPU those cycles; WR_Y issued after release; no write lost or duplicated.
REQ-039 SHALL cover: ANIM_DIV=2, 8 frames -> ctrl low bits sequence 00,01,01,10,10,11,11,00.
REQ-040 SHALL cover: reset pulsed during WR_X -> the following cycle shows m_cs=0, busy=0; the next frame restarts from x=step, y=step.

Source files
------------

// File: rtl/ghost_motion_ctrl.sv
// Ghost sprite motion sequencer: once per frame moves the ghost,
// bounces it off the screen edges and pushes x/y/ctrl to the sprite slot.
module ghost_motion_ctrl #(
    parameter int H_MAX    = 640,
    parameter int V_MAX    = 480,
    parameter int SPR_W    = 16,
    parameter int ANIM_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        cpu_cs,
    input  logic        cpu_write,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    input  logic        auto_en,
    input  logic [3:0]  step,
    input  logic [2:0]  ctrl_hi,
    output logic        m_cs,
    output logic        m_write,
    output logic [13:0] m_addr,
    output logic [31:0] m_wr_data,
    output logic        busy,
    output logic        frame_tick
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WR_X,
        WR_Y,
        WR_CTRL
    } state_t;

    localparam logic signed [11:0] X_LIM   = 12'(H_MAX - SPR_W);
    localparam logic signed [11:0] Y_LIM   = 12'(V_MAX - SPR_W);
    localparam logic [10:0]        V_LINE  = 11'(V_MAX);
    localparam logic [7:0]         FC_LAST = 8'(ANIM_DIV - 1);

    state_t      state;
    state_t      state_nx;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        dx_neg;
    logic        dy_neg;
    logic [7:0]  fcnt;
    logic [1:0]  anim;
    logic        at_pix;
    logic        at_pix_q;
    logic        grant;
    logic        snoop_x;
    logic        snoop_y;
    logic [11:0] x_calc;
    logic [11:0] y_calc;
    logic        fsm_cs;
    logic [13:0] fsm_addr;
    logic [31:0] fsm_data;

    // One axis step: returns {direction_negative, new_position}
    function automatic logic [11:0] axis_next(
        input logic [10:0]        pos,
        input logic               neg,
        input logic [3:0]         s,
        input logic signed [11:0] lim
    );
        logic signed [11:0] n;
        n = neg ? ($signed({1'b0, pos}) - $signed({8'b0, s}))
                : ($signed({1'b0, pos}) + $signed({8'b0, s}));
        if (n > lim) begin
            return {1'b1, lim[10:0]};
        end else if (n < 0) begin
            return {1'b0, 11'd0};
        end else begin
            return {neg, n[10:0]};
        end
    endfunction

    assign at_pix  = (x == 11'd0) && (y == V_LINE);
    assign grant   = !cpu_cs;
    assign snoop_x = cpu_cs && cpu_write && cpu_addr[13] &&
                     (cpu_addr[1:0] == 2'b01);
    assign snoop_y = cpu_cs && cpu_write && cpu_addr[13] &&
                     (cpu_addr[1:0] == 2'b10);
    assign busy    = (state != IDLE);

    // Next positions for both axes, used only in CALC
    always_comb begin
        x_calc = axis_next(x_pos, dx_neg, step, X_LIM);
        y_calc = axis_next(y_pos, dy_neg, step, Y_LIM);
    end

    // Frame-start pulse on the first cycle the counter sits at the pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            at_pix_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            at_pix_q   <= at_pix;
            frame_tick <= at_pix && !at_pix_q;
        end
    end

    // Position, direction and animation state; CPU snoops win over CALC
    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos  <= 11'd0;
            y_pos  <= 11'd0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            fcnt   <= 8'd0;
            anim   <= 2'd0;
        end else begin
            if (state == CALC) begin
                {dx_neg, x_pos} <= x_calc;
                {dy_neg, y_pos} <= y_calc;
                if (fcnt == FC_LAST) begin
                    fcnt <= 8'd0;
                    anim <= anim + 2'd1;
                end else begin
                    fcnt <= fcnt + 8'd1;
                end
            end
            if (snoop_x) begin
                x_pos <= cpu_wr_data[10:0];
            end
            if (snoop_y) begin
                y_pos <= cpu_wr_data[10:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and the write each state wants to issue
    always_comb begin
        state_nx = state;
        fsm_cs   = 1'b0;
        fsm_addr = 14'd0;
        fsm_data = 32'd0;
        unique case (state)
            IDLE: begin
                if (frame_tick && auto_en) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                state_nx = WR_X;
            end
            WR_X: begin
                fsm_cs   = 1'b1;
                fsm_addr = 14'h2001;
                fsm_data = {21'b0, x_pos};
                if (grant) begin
                    state_nx = WR_Y;
                end
            end
            WR_Y: begin
                fsm_cs   = 1'b1;
                fsm_addr = 14'h2002;
                fsm_data = {21'b0, y_pos};
                if (grant) begin
                    state_nx = WR_CTRL;
                end
            end
            WR_CTRL: begin
                fsm_cs   = 1'b1;
                fsm_addr = 14'h2003;
                fsm_data = {27'b0, ctrl_hi, anim};
                if (grant) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus mux: CPU first, then the sequencer, otherwise idle
    always_comb begin
        m_cs      = 1'b0;
        m_write   = 1'b0;
        m_addr    = 14'd0;
        m_wr_data = 32'd0;
        if (cpu_cs) begin
            m_cs      = 1'b1;
            m_write   = cpu_write;
            m_addr    = cpu_addr;
            m_wr_data = cpu_wr_data;
        end else if (fsm_cs && !reset) begin
            m_cs      = 1'b1;
            m_write   = 1'b1;
            m_addr    = fsm_addr;
            m_wr_data = fsm_data;
        end
    end

endmodule
